// File: rtl/usb_rd_ctrl.sv
// Purpose : FX3 slave-FIFO reader; pulls PKT_WORDS-word packets into round-robin RAM banks.
// Latency : SLRD_n low -> RD_LAT cycles -> DQ captured -> wren_for_ram/wr_data/wr_addr one cycle later.
// Backpr. : FLAGA low pauses strobes mid-packet; bank_free[bank_sel] low holds the block in IDLE.
//
// Ports:
//   clk, rst_n        single clock, async active-low reset
//   enable            permits new packet starts (a packet in flight always completes)
//   USB3_FLAGA/DQ     FX3 data-available flag and 32-bit data bus
//   bank_free         per-bank "may be overwritten" flags
//   USB3_SLOE_n/SLRD_n FX3 output enable and read strobe (active-low)
//   usb_rd_state      current state code
//   wr_data/wr_addr   captured word and its index within the packet
//   wren_for_ram      one-hot write enable for the bank in bank_sel
//   pkt_done          one-cycle pulse after the last word of a packet is written
//   bank_sel          bank receiving the current or next packet
module usb_rd_ctrl #(
  parameter int PKT_WORDS = 256,
  parameter int RD_LAT    = 3,
  parameter int NUM_RAM   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               USB3_FLAGA,
  input  logic [31:0]        USB3_DQ,
  input  logic [NUM_RAM-1:0] bank_free,
  output logic               USB3_SLOE_n,
  output logic               USB3_SLRD_n,
  output logic [3:0]         usb_rd_state,
  output logic [31:0]        wr_data,
  output logic [7:0]         wr_addr,
  output logic [NUM_RAM-1:0] wren_for_ram,
  output logic               pkt_done,
  output logic [3:0]         bank_sel
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SETTLE1 = 4'd3;
  localparam logic [3:0] S_SETTLE2 = 4'd4;
  localparam logic [3:0] S_OE      = 4'd5;
  localparam logic [3:0] S_READ    = 4'd6;
  localparam logic [3:0] S_TAIL    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [8:0] PKT_CNT   = 9'(PKT_WORDS);
  localparam logic [8:0] PKT_LAST  = 9'(PKT_WORDS - 1);
  localparam logic [3:0] BANK_LAST = 4'(NUM_RAM - 1);

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [8:0]        rd_cnt;
  logic [8:0]        wr_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic              strobe;
  logic              word_vld;

  // The strobe follows FLAGA combinationally so a FIFO-empty cycle never
  // issues a read; rd_cnt only advances on cycles that actually strobe.
  assign strobe   = (state == S_READ) && USB3_FLAGA && (rd_cnt < PKT_CNT);
  assign word_vld = rd_pipe[RD_LAT-1];

  assign USB3_SLRD_n  = ~strobe;
  assign USB3_SLOE_n  = ~((state == S_OE) || (state == S_READ) || (state == S_TAIL));
  assign pkt_done     = (state == S_DONE);
  assign usb_rd_state = state;

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (enable && USB3_FLAGA && bank_free[bank_sel]) state_nxt = S_SETTLE1;
        else                                              state_nxt = S_IDLE;
      end
      S_SETTLE1: state_nxt = USB3_FLAGA ? S_SETTLE2 : S_IDLE;
      S_SETTLE2: state_nxt = USB3_FLAGA ? S_OE : S_IDLE;
      S_OE:      state_nxt = S_READ;
      S_READ: begin
        // Leave on the final strobe so no dead cycle sits between READ and TAIL.
        if (strobe && (rd_cnt == PKT_LAST)) state_nxt = S_TAIL;
        else                                state_nxt = S_READ;
      end
      S_TAIL: begin
        // Wait for the read-latency pipeline to drain every requested word.
        if (wr_cnt == PKT_CNT) state_nxt = S_DONE;
        else                   state_nxt = S_TAIL;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      rd_pipe      <= '0;
      wr_data      <= '0;
      wr_addr      <= '0;
      wren_for_ram <= '0;
      bank_sel     <= '0;
    end else begin
      state   <= state_nxt;
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(strobe);

      if (state == S_OE)  rd_cnt <= '0;
      else if (strobe)    rd_cnt <= rd_cnt + 9'd1;

      wren_for_ram <= '0;
      if (word_vld) begin
        wr_data      <= USB3_DQ;
        wr_addr      <= wr_cnt[7:0];
        wren_for_ram <= NUM_RAM'(1) << bank_sel;
      end

      // The pipeline is empty in OE (the previous packet drained in TAIL),
      // so clearing here never loses a write.
      if (state == S_OE)  wr_cnt <= '0;
      else if (word_vld)  wr_cnt <= wr_cnt + 9'd1;

      if (state == S_DONE) begin
        if (bank_sel == BANK_LAST) bank_sel <= '0;
        else                       bank_sel <= bank_sel + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_rd_ctrl.sv
// Bench for usb_rd_ctrl: an FX3 slave-FIFO model answers each read strobe
// with a random word RD_LAT cycles later; every word must then appear once,
// in order, at the right address and bank.
module tb_usb_rd_ctrl;
  localparam int PKT = 256;
  localparam int LAT = 3;
  localparam int NR  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          USB3_FLAGA = 1'b0;
  logic [31:0]   USB3_DQ = '0;
  logic [NR-1:0] bank_free = '1;
  logic          USB3_SLOE_n;
  logic          USB3_SLRD_n;
  logic [3:0]    usb_rd_state;
  logic [31:0]   wr_data;
  logic [7:0]    wr_addr;
  logic [NR-1:0] wren_for_ram;
  logic          pkt_done;
  logic [3:0]    bank_sel;

  always #5 clk = ~clk;

  usb_rd_ctrl #(.PKT_WORDS(PKT), .RD_LAT(LAT), .NUM_RAM(NR)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .USB3_FLAGA(USB3_FLAGA),
    .USB3_DQ(USB3_DQ), .bank_free(bank_free), .USB3_SLOE_n(USB3_SLOE_n),
    .USB3_SLRD_n(USB3_SLRD_n), .usb_rd_state(usb_rd_state), .wr_data(wr_data),
    .wr_addr(wr_addr), .wren_for_ram(wren_for_ram), .pkt_done(pkt_done),
    .bank_sel(bank_sel)
  );

  typedef struct {
    int          due;
    logic [31:0] word;
    int          addr;
    int          bank;
  } xfer_t;

  xfer_t dq_q[$];   // words promised by the FX3 model, waiting for their bus cycle
  xfer_t wr_q[$];   // words on the bus, waiting for their RAM write

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int n_str   = 0;  // strobes since reset
  int n_wr    = 0;  // words written in the current packet
  int done_cnt = 0;
  int done_due = -1;
  int base;
  int seq_state[5] = '{0, 3, 4, 5, 6};
  int seq_sloe[5]  = '{1, 1, 1, 0, 0};

  logic          rst_v = 1'b0;
  logic          en    = 1'b0;
  logic          flaga = 1'b0;
  logic [NR-1:0] bfree = '1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, then check outputs.
  task automatic step();
    xfer_t         x;
    logic [NR-1:0] oh;
    @(negedge clk);
    cyc++;
    rst_n      = rst_v;
    enable     = en;
    USB3_FLAGA = flaga;
    bank_free  = bfree;
    USB3_DQ    = $urandom;
    if (dq_q.size() > 0 && dq_q[0].due == cyc) begin
      x = dq_q.pop_front();
      USB3_DQ = x.word;
      x.due = cyc + 1;
      wr_q.push_back(x);
    end
    #1;
    if (!rst_v) begin
      dq_q.delete();
      wr_q.delete();
      n_str = 0; n_wr = 0; done_cnt = 0; done_due = -1;
      chk("rst_state",  32'(usb_rd_state), 0);
      chk("rst_sloe",   32'(USB3_SLOE_n), 1);
      chk("rst_slrd",   32'(USB3_SLRD_n), 1);
      chk("rst_wren",   32'(wren_for_ram), 0);
      chk("rst_done",   32'(pkt_done), 0);
      chk("rst_data",   wr_data, 0);
      chk("rst_addr",   32'(wr_addr), 0);
      chk("rst_bank",   32'(bank_sel), 0);
      return;
    end
    if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
      x = wr_q.pop_front();
      oh = '0;
      oh[x.bank] = 1'b1;
      chk("wren",    32'(wren_for_ram), 32'(oh));
      chk("wr_data", wr_data, x.word);
      chk("wr_addr", 32'(wr_addr), 32'(x.addr));
      n_wr = x.addr + 1;
      if (x.addr == PKT - 1) done_due = cyc + 1;
    end else begin
      chk("wren_quiet", 32'(wren_for_ram), 0);
    end
    chk("pkt_done", 32'(pkt_done), 32'(done_due == cyc));
    chk("bank_sel", 32'(bank_sel), 32'(done_cnt % NR));
    if (done_due == cyc) begin
      done_cnt++;
      n_wr = 0;
    end
    if (!flaga) chk("slrd_paused", 32'(USB3_SLRD_n), 1);
    if (!USB3_SLRD_n) begin
      chk("sloe_with_slrd", 32'(USB3_SLOE_n), 0);
      x.due  = cyc + LAT;
      x.word = $urandom;
      x.addr = n_str % PKT;
      x.bank = (n_str / PKT) % NR;
      dq_q.push_back(x);
      n_str++;
    end
  endtask

  task automatic wait_done(input int limit);
    int start;
    start = done_cnt;
    for (int i = 0; i < limit; i++) begin
      step();
      if (done_cnt != start) return;
    end
    chk("done_timeout", 32'(done_cnt - start), 1);
  endtask

  task automatic wait_strobes(input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (n_str - base >= n) return;
      step();
    end
    chk("strobe_timeout", 32'(n_str - base), 32'(n));
  endtask

  task automatic wait_writes(input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (n_wr >= n) return;
      step();
    end
    chk("write_timeout", 32'(n_wr), 32'(n));
  endtask

  initial begin
    // Reset held for a few cycles.
    repeat (3) step();

    // First packet: fixed start sequence, full packet to bank 0.
    rst_v = 1'b1; en = 1'b1; flaga = 1'b1;
    base = n_str;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("start_state", 32'(usb_rd_state), 32'(seq_state[i]));
      chk("start_sloe",  32'(USB3_SLOE_n), 32'(seq_sloe[i]));
    end
    wait_done(400);
    chk("pkt0_strobes", 32'(n_str - base), PKT);
    step();
    chk("pkt0_bank", 32'(bank_sel), 1);

    // FLAGA drop for 10 cycles after 100 strobes.
    base = n_str;
    wait_strobes(100, 400);
    flaga = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_hold", 32'(n_str - base), 100);
    end
    flaga = 1'b1;
    wait_done(500);
    chk("pkt1_strobes", 32'(n_str - base), PKT);

    // FLAGA falls while in SETTLE2: back to IDLE, no enables.
    flaga = 1'b0;
    repeat (3) step();
    flaga = 1'b1;
    step(); chk("abort_s0", 32'(usb_rd_state), 0);
    step(); chk("abort_s3", 32'(usb_rd_state), 3);
    flaga = 1'b0;
    step(); chk("abort_s4", 32'(usb_rd_state), 4);
    step(); chk("abort_idle", 32'(usb_rd_state), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_sloe", 32'(USB3_SLOE_n), 1);
      chk("abort_slrd", 32'(USB3_SLRD_n), 1);
    end

    // Current bank (2) busy: hold in IDLE, start right after it frees.
    bfree[2] = 1'b0;
    flaga = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("blocked_state", 32'(usb_rd_state), 0);
      chk("blocked_sloe",  32'(USB3_SLOE_n), 1);
    end
    bfree[2] = 1'b1;
    step(); chk("unblock_s0", 32'(usb_rd_state), 0);
    step(); chk("unblock_s3", 32'(usb_rd_state), 3);
    base = n_str;
    wait_done(500);
    chk("pkt2_strobes", 32'(n_str - base), PKT);

    // enable dropped mid-packet: packet completes, no new start.
    base = n_str;
    wait_strobes(10, 100);
    en = 1'b0;
    wait_done(500);
    chk("pkt3_strobes", 32'(n_str - base), PKT);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("disabled_state", 32'(usb_rd_state), 0);
      chk("disabled_sloe",  32'(USB3_SLOE_n), 1);
    end

    // Back-to-back packets with random FLAGA gaps, through the bank wrap.
    en = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      flaga = ($urandom_range(0, 9) != 0);
      step();
      if (done_cnt >= 18) break;
    end
    chk("b2b_packets", 32'(done_cnt >= 18), 1);

    // Reset after 50 writes: partial packet dropped, restart at bank 0 addr 0.
    flaga = 1'b1;
    wait_writes(50, 400);
    rst_v = 1'b0;
    step();
    rst_v = 1'b1;
    base = n_str;
    wait_done(500);
    chk("post_rst_strobes", 32'(n_str - base), PKT);
    step();
    chk("post_rst_bank", 32'(bank_sel), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
